cpu_core: RTL and testbench

Parametrised multi-cycle processor core, the next generation of the fixed-width four-register top. Data width, register count and PC width are configurable. Instructions are fetched over a valid/ready memory handshake instead of a combinational ROM lookup. Adds SUB, LI, JMP and HALT, plus retire and halted status for the testbench and for future pipeline work.

---
 rtl/cpu_core.sv | 129 ++++++++++++
 tb/tb_cpu_core.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Parametrised multi-cycle core: fetch over a valid/ready handshake, execute in one cycle,
// then stop in HALT until reset. The register file and pc are always visible.
module cpu_core #(
    parameter int unsigned XLEN  = 8,
    parameter int unsigned NREGS = 4,
    parameter int unsigned PC_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [15:0]     imem_rdata,
    output logic [PC_W-1:0] pc,
    output logic [XLEN-1:0] regs [0:NREGS-1],
    output logic            retire,
    output logic            halted
);
    localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic [PC_W-1:0]   w_pc_inc;
    logic [15:0]       r_ir;
    logic [XLEN-1:0]   r_regs [0:NREGS-1];
    logic [3:0]        w_op;
    logic [RIDX_W-1:0] w_rd;
    logic [RIDX_W-1:0] w_rs1;
    logic [RIDX_W-1:0] w_rs2;
    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    logic [XLEN-1:0]   w_wr_data;
    logic              w_wr_en;

    // Register fields keep only the low index bits; the upper bits are ignored.
    assign w_op     = r_ir[15:12];
    assign w_rd     = RIDX_W'(r_ir[11:8]);
    assign w_rs1    = RIDX_W'(r_ir[7:4]);
    assign w_rs2    = RIDX_W'(r_ir[3:0]);
    assign w_a      = r_regs[w_rs1];
    assign w_b      = r_regs[w_rs2];
    assign w_pc_inc = r_pc + PC_W'(1);

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign regs      = r_regs;

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_wr_en      = 1'b0;
        w_wr_data    = '0;
        imem_req     = 1'b0;
        retire       = 1'b0;
        halted       = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                imem_req = ~reset;
                if (imem_ready) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                retire       = 1'b1;
                w_pc_next    = w_pc_inc;
                w_next_state = S_FETCH;
                case (w_op)
                    4'h0: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_a + w_b;
                    end
                    4'h1: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_a + XLEN'(r_ir[3:0]);
                    end
                    4'h2: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_a - w_b;
                    end
                    4'h3: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = XLEN'(r_ir[7:0]);
                    end
                    4'h4: begin
                        if (w_a != r_regs[0]) begin
                            w_pc_next = PC_W'(r_ir[3:0]);
                        end
                    end
                    4'h5: w_pc_next = PC_W'(r_ir[7:0]);
                    4'hF: begin
                        // pc stays on the HALT instruction
                        w_pc_next    = r_pc;
                        w_next_state = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_regs  <= '{default: '0};
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (r_state == S_FETCH && imem_ready) begin
                r_ir <= imem_rdata;
            end
            if (w_wr_en) begin
                r_regs[w_rd] <= w_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: an ISA-level model checks every retired instruction on an 8-bit and a 4-bit core.
module tb_cpu_core;

    logic        clk;
    logic        rst_a, rdy_a, req_a, retire_a, halted_a;
    logic [3:0]  addr_a, pc_a;
    logic [15:0] rdata_a;
    logic [7:0]  regs_a [0:3];
    logic        rst_b, rdy_b, req_b, retire_b, halted_b;
    logic [3:0]  addr_b, pc_b;
    logic [15:0] rdata_b;
    logic [3:0]  regs_b [0:3];

    cpu_core #(.XLEN(8), .NREGS(4), .PC_W(4)) dut_a (
        .clk(clk), .reset(rst_a), .imem_req(req_a), .imem_addr(addr_a), .imem_ready(rdy_a),
        .imem_rdata(rdata_a), .pc(pc_a), .regs(regs_a), .retire(retire_a), .halted(halted_a)
    );

    cpu_core #(.XLEN(4), .NREGS(4), .PC_W(4)) dut_b (
        .clk(clk), .reset(rst_b), .imem_req(req_b), .imem_addr(addr_b), .imem_ready(rdy_b),
        .imem_rdata(rdata_b), .pc(pc_b), .regs(regs_b), .retire(retire_b), .halted(halted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] prog [0:15];
    int          cur_sel = 0;
    int          fixed_wait = 0;
    bit          wait_rand = 0;
    bit          spur = 0;

    int          m_regs [0:3];
    int          m_pc;
    bit          m_halt;

    int          res_retires, res_halt_cyc, res_trace_err, res_addr_err, res_exp_cycles;
    logic        res_req0;
    logic [3:0]  res_addr0;
    int          res_fetches [$];

    function automatic logic v_req();
        return (cur_sel == 1) ? req_b : req_a;
    endfunction
    function automatic logic [3:0] v_addr();
        return (cur_sel == 1) ? addr_b : addr_a;
    endfunction
    function automatic logic [3:0] v_pc();
        return (cur_sel == 1) ? pc_b : pc_a;
    endfunction
    function automatic logic v_retire();
        return (cur_sel == 1) ? retire_b : retire_a;
    endfunction
    function automatic logic v_halted();
        return (cur_sel == 1) ? halted_b : halted_a;
    endfunction
    function automatic logic [7:0] v_reg(input int i);
        logic [1:0] idx;
        idx = 2'(i);
        return (cur_sel == 1) ? {4'b0, regs_b[idx]} : regs_a[idx];
    endfunction

    task automatic set_mem(input logic r, input logic [15:0] d);
        if (cur_sel == 1) begin
            rdy_b = r; rdata_b = d;
        end else begin
            rdy_a = r; rdata_a = d;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
    endtask

    // Instruction-level semantics, independent of any cycle timing.
    task automatic model_exec();
        logic [15:0] ins;
        int op, rd, rs1, rs2, imm4, imm8, xm;
        ins  = prog[m_pc];
        op   = int'(ins[15:12]);
        rd   = int'(ins[11:8]) % 4;
        rs1  = int'(ins[7:4]) % 4;
        rs2  = int'(ins[3:0]) % 4;
        imm4 = int'(ins[3:0]);
        imm8 = int'(ins[7:0]);
        xm   = ((cur_sel == 1) ? 16 : 256) - 1;
        case (op)
            0: m_regs[rd] = (m_regs[rs1] + m_regs[rs2]) & xm;
            1: m_regs[rd] = (m_regs[rs1] + imm4) & xm;
            2: m_regs[rd] = (m_regs[rs1] - m_regs[rs2]) & xm;
            3: m_regs[rd] = imm8 & xm;
            default: ;
        endcase
        if (op == 4) m_pc = (m_regs[rs1] != m_regs[0]) ? imm4 % 16 : (m_pc + 1) % 16;
        else if (op == 5) m_pc = imm8 % 16;
        else if (op == 15) m_halt = 1;
        else m_pc = (m_pc + 1) % 16;
    endtask

    // Resets the selected core, serves fetches from prog[] and tracks it against the model.
    task automatic run(input int sel, input int budget);
        int         rem;
        bit         active;
        bit         pend;
        logic [3:0] hold;
        int         stop_at;
        rem = 0; active = 0; pend = 0; hold = '0; stop_at = -1;
        cur_sel = sel;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_pc = 0; m_halt = 0;
        res_retires = 0; res_halt_cyc = 0; res_trace_err = 0; res_addr_err = 0; res_exp_cycles = 0;
        res_fetches.delete();
        rst_a = 1'b1; rst_b = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0;
        repeat (2) @(negedge clk);
        if (sel == 1) rst_b = 1'b0; else rst_a = 1'b0;
        #1;
        for (int cyc = 0; cyc <= budget; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 0) begin
                res_req0  = v_req();
                res_addr0 = v_addr();
            end
            if (pend) begin
                pend = 0;
                model_exec();
                if (v_pc() !== 4'(m_pc) || v_halted() !== m_halt) res_trace_err++;
                for (int i = 0; i < 4; i++) if (v_reg(i) !== 8'(m_regs[i])) res_trace_err++;
            end
            if (v_retire() === 1'b1) begin
                res_retires++;
                pend = 1;
            end
            if (v_halted() === 1'b1 && res_halt_cyc == 0) begin
                res_halt_cyc = cyc;
                stop_at = cyc + 4;
            end
            if (cyc == stop_at) break;
            if (v_req() === 1'b1) begin
                if (!active) begin
                    active = 1;
                    rem = wait_rand ? int'($urandom_range(0, 3)) : fixed_wait;
                    hold = v_addr();
                    res_exp_cycles += rem + 2;
                    if (v_addr() !== 4'(m_pc)) res_trace_err++;
                end else if (v_addr() !== hold) begin
                    res_addr_err++;
                end
                if (rem == 0) begin
                    set_mem(1'b1, prog[v_addr()]);
                    active = 0;
                    res_fetches.push_back(int'(v_addr()));
                end else begin
                    set_mem(1'b0, 16'($urandom));
                    rem--;
                end
            end else if (spur && $urandom_range(0, 1) == 1) begin
                set_mem(1'b1, 16'($urandom));
            end else begin
                set_mem(1'b0, '0);
            end
        end
        set_mem(1'b0, '0);
    endtask

    task automatic test_li();
        clear_prog();
        prog[0] = 16'h3105; prog[1] = 16'h3203; prog[2] = 16'h0312; prog[3] = 16'hF000;
        fixed_wait = 0; wait_rand = 0; spur = 0;
        run(0, 100);
        checks++;
        if (res_req0 !== 1'b1 || res_addr0 !== 4'h0) begin
            errors++; $display("FAIL li_first_req: req=%b addr=%h, required req=1 addr=0", res_req0, res_addr0);
        end
        checks++;
        if (regs_a[3] !== 8'h08) begin errors++; $display("FAIL li_r3: got %h, required 08", regs_a[3]); end
        checks++;
        if (res_retires !== 4) begin errors++; $display("FAIL li_retires: got %0d, required 4", res_retires); end
        checks++;
        if (res_halt_cyc !== 8) begin errors++; $display("FAIL li_halt_cycle: got %0d, required 8", res_halt_cyc); end
        checks++;
        if (pc_a !== 4'h3 || halted_a !== 1'b1) begin
            errors++; $display("FAIL li_halt_state: pc=%h halted=%b, required pc=3 halted=1", pc_a, halted_a);
        end
        checks++;
        if (res_trace_err !== 0) begin errors++; $display("FAIL li_trace: %0d mismatches, required 0", res_trace_err); end
    endtask

    task automatic test_reset_async();
        bit zero;
        @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        checks++;
        if (pc_a !== 4'h0) begin errors++; $display("FAIL rst_pc: got %h, required 0", pc_a); end
        zero = 1;
        for (int i = 0; i < 4; i++) if (regs_a[i] !== 8'h00) zero = 0;
        checks++;
        if (!zero) begin errors++; $display("FAIL rst_regs: r1=%h r2=%h r3=%h, required all 0", regs_a[1], regs_a[2], regs_a[3]); end
        checks++;
        if (retire_a !== 1'b0 || halted_a !== 1'b0) begin
            errors++; $display("FAIL rst_status: retire=%b halted=%b, required 0 0", retire_a, halted_a);
        end
        @(negedge clk);
        checks++;
        if (req_a !== 1'b0) begin errors++; $display("FAIL rst_req_gated: got %b, required 0", req_a); end
    endtask

    task automatic test_wrap_sub();
        clear_prog();
        prog[0] = 16'h31FF; prog[1] = 16'h1112; prog[2] = 16'h2201; prog[3] = 16'hF000;
        fixed_wait = 0; wait_rand = 0; spur = 0;
        run(0, 100);
        checks++;
        if (regs_a[1] !== 8'h01 || regs_a[2] !== 8'hFF) begin
            errors++; $display("FAIL wrap_sub: r1=%h r2=%h, required r1=01 r2=FF", regs_a[1], regs_a[2]);
        end
        checks++;
        if (res_trace_err !== 0) begin errors++; $display("FAIL wrap_sub_trace: %0d mismatches, required 0", res_trace_err); end
    endtask

    task automatic test_loop_xlen4();
        clear_prog();
        prog[0] = 16'h3103; prog[1] = 16'h111F; prog[2] = 16'h4011; prog[3] = 16'h32FF; prog[4] = 16'hF000;
        fixed_wait = 0; wait_rand = 0; spur = 0;
        run(1, 200);
        checks++;
        if (regs_b[1] !== 4'h0 || regs_b[2] !== 4'hF) begin
            errors++; $display("FAIL loop4_regs: r1=%h r2=%h, required r1=0 r2=F", regs_b[1], regs_b[2]);
        end
        checks++;
        if (res_retires !== 9 || res_halt_cyc !== 18) begin
            errors++; $display("FAIL loop4_count: retires=%0d halt_cyc=%0d, required 9 18", res_retires, res_halt_cyc);
        end
        checks++;
        if (halted_b !== 1'b1 || pc_b !== 4'h4) begin
            errors++; $display("FAIL loop4_halt: halted=%b pc=%h, required 1 4", halted_b, pc_b);
        end
        checks++;
        if (res_trace_err !== 0) begin errors++; $display("FAIL loop4_trace: %0d mismatches, required 0", res_trace_err); end
        rst_b = 1'b1;
    endtask

    task automatic test_wait_states();
        clear_prog();
        prog[0] = 16'h3105; prog[1] = 16'h3203; prog[2] = 16'h0312; prog[3] = 16'hF000;
        fixed_wait = 3; wait_rand = 0; spur = 0;
        run(0, 200);
        checks++;
        if (regs_a[3] !== 8'h08) begin errors++; $display("FAIL wait_r3: got %h, required 08", regs_a[3]); end
        checks++;
        if (res_halt_cyc !== 20) begin errors++; $display("FAIL wait_halt_cycle: got %0d, required 20", res_halt_cyc); end
        checks++;
        if (res_addr_err !== 0) begin errors++; $display("FAIL wait_addr_stable: %0d changes, required 0", res_addr_err); end
        checks++;
        if (res_retires !== 4 || res_trace_err !== 0) begin
            errors++; $display("FAIL wait_trace: retires=%0d mism=%0d, required 4 0", res_retires, res_trace_err);
        end
        fixed_wait = 0;
    endtask

    task automatic test_pc_wrap();
        int exp_f [5];
        bit ok;
        exp_f = '{0, 1, 15, 0, 2};
        clear_prog();
        prog[0] = 16'h4012; prog[1] = 16'h501F; prog[15] = 16'h1111; prog[2] = 16'hF000;
        fixed_wait = 0; wait_rand = 0; spur = 0;
        run(0, 100);
        ok = (res_fetches.size() == 5);
        if (ok) for (int i = 0; i < 5; i++) if (res_fetches[i] != exp_f[i]) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL pcwrap_fetch_order: got %p, required 0 1 15 0 2", res_fetches); end
        checks++;
        if (regs_a[1] !== 8'h01 || pc_a !== 4'h2) begin
            errors++; $display("FAIL pcwrap_final: r1=%h pc=%h, required 01 2", regs_a[1], pc_a);
        end
        checks++;
        if (res_trace_err !== 0) begin errors++; $display("FAIL pcwrap_trace: %0d mismatches, required 0", res_trace_err); end
    endtask

    task automatic test_midfetch();
        bit zero;
        clear_prog();
        prog[0] = 16'h3177; prog[1] = 16'h3255;
        cur_sel = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        set_mem(1'b0, '0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        #1 set_mem(1'b1, prog[0]);
        @(negedge clk) set_mem(1'b0, '0);
        @(negedge clk);
        checks++;
        if (regs_a[1] !== 8'h77 || req_a !== 1'b1 || addr_a !== 4'h1) begin
            errors++; $display("FAIL mid_setup: r1=%h req=%b addr=%h, required 77 1 1", regs_a[1], req_a, addr_a);
        end
        @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        zero = 1;
        for (int i = 0; i < 4; i++) if (regs_a[i] !== 8'h00) zero = 0;
        checks++;
        if (pc_a !== 4'h0 || !zero || retire_a !== 1'b0) begin
            errors++; $display("FAIL mid_reset: pc=%h r1=%h retire=%b, required 0 00 0", pc_a, regs_a[1], retire_a);
        end
        set_mem(1'b1, prog[1]);
        @(negedge clk);
        set_mem(1'b0, '0);
        rst_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (retire_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 4'h0 || regs_a[2] !== 8'h00) begin
                errors++;
                $display("FAIL mid_restart: retire=%b req=%b addr=%h r2=%h, required 0 1 0 00", retire_a, req_a, addr_a, regs_a[2]);
            end
            @(negedge clk);
        end
        set_mem(1'b1, prog[0]);
        @(negedge clk) set_mem(1'b0, '0);
        checks++;
        if (retire_a !== 1'b1) begin errors++; $display("FAIL mid_exec: retire=%b, required 1", retire_a); end
        @(negedge clk);
        checks++;
        if (regs_a[1] !== 8'h77 || regs_a[2] !== 8'h00 || pc_a !== 4'h1) begin
            errors++; $display("FAIL mid_result: r1=%h r2=%h pc=%h, required 77 00 1", regs_a[1], regs_a[2], pc_a);
        end
    endtask

    task automatic test_random();
        int         len;
        logic [3:0] opc;
        for (int it = 0; it < 20; it++) begin
            len = int'($urandom_range(3, 14));
            clear_prog();
            for (int k = 0; k < len; k++) begin
                case ($urandom_range(0, 5))
                    0:       opc = 4'h0;
                    1:       opc = 4'h1;
                    2:       opc = 4'h2;
                    3, 4:    opc = 4'h3;
                    default: opc = 4'($urandom_range(6, 14));
                endcase
                prog[k] = {opc, 12'($urandom)};
            end
            wait_rand = 1; spur = 1;
            run(it % 2, 300);
            checks++;
            if (res_trace_err !== 0) begin errors++; $display("FAIL rnd_trace it=%0d: %0d mismatches, required 0", it, res_trace_err); end
            checks++;
            if (res_retires !== len + 1) begin errors++; $display("FAIL rnd_retires it=%0d: got %0d, required %0d", it, res_retires, len + 1); end
            checks++;
            if (res_halt_cyc !== res_exp_cycles) begin
                errors++; $display("FAIL rnd_cycles it=%0d: got %0d, required %0d", it, res_halt_cyc, res_exp_cycles);
            end
            checks++;
            if (res_addr_err !== 0) begin errors++; $display("FAIL rnd_addr_stable it=%0d: %0d changes, required 0", it, res_addr_err); end
        end
        wait_rand = 0; spur = 0;
        rst_b = 1'b1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0;
        rdata_a = '0; rdata_b = '0;
        clear_prog();
        test_li();
        test_reset_async();
        test_wrap_sub();
        test_loop_xlen4();
        test_wait_states();
        test_pc_wrap();
        test_midfetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
